seq_table_counter: RTL

Synchronous, programmable-sequence counter and the parametrised successor of the fixed 0,2,4,7 sequence counter.
- Steps through a run-time writable table of DEPTH values of WIDTH bits each.
- Supports up and down direction, continuous (wrap) and one-shot modes, a terminal-count pulse and a done flag.
- Used as a pattern or divider-phase generator in the counters/dividers group. Fully synchronous: no derived clocks.

---
 rtl/seq_cnt_pkg.sv | 15 +
 rtl/seq_cnt_table.sv | 67 ++++++
 rtl/seq_table_counter.sv | 117 +++++++++++
 3 files changed

// File: rtl/seq_cnt_pkg.sv
// Shared types and constants for the programmable-sequence counter.
package seq_cnt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/seq_cnt_table.sv
// DEPTH x WIDTH sequence table: reset load from INIT_SEQ, one write port, one combinational read port.
// Optional even-parity storage and sticky error flag when SEQ_CNT_PARITY_EN is defined.
module seq_cnt_table
  import seq_cnt_pkg::*;
#(
  parameter int                     WIDTH    = 3,
  parameter int                     DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0] INIT_SEQ = {3'd7, 3'd4, 3'd2, 3'd0},
  parameter int                     IDXW     = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             we_i,
  input  logic [IDXW-1:0]  wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [IDXW-1:0]  rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             par_clr_i,
  output logic             par_err_o
);

  logic [DEPTH-1:0][WIDTH-1:0] tbl_q;
  logic                        wr_ok;

  // Addresses beyond the last entry only exist for non-power-of-2 DEPTH; such writes are dropped.
  assign wr_ok = we_i && ({1'b0, wr_idx_i} <= (IDXW+1)'(DEPTH-1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tbl_q <= INIT_SEQ;
    end else if (wr_ok) begin
      tbl_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = tbl_q[rd_idx_i];

`ifdef SEQ_CNT_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             par_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= ^INIT_SEQ[i*WIDTH +: WIDTH];
      end
      par_err_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        par_q[wr_idx_i] <= ^wr_data_i;
      end
      if (par_clr_i) begin
        par_err_q <= 1'b0;
      end else if ((^rd_data_o) != par_q[rd_idx_i]) begin
        par_err_q <= 1'b1;
      end
    end
  end

  assign par_err_o = par_err_q;
`else
  logic unused_par_clr;
  assign unused_par_clr = par_clr_i;
  assign par_err_o      = 1'b0;
`endif

endmodule

// File: rtl/seq_table_counter.sv
// Programmable-sequence counter: up/down, wrap/one-shot, terminal-count pulse and done flag.
// Optional parity checking of the table is enabled with the macro SEQ_CNT_PARITY_EN.
module seq_table_counter
  import seq_cnt_pkg::*;
#(
  parameter int                     WIDTH    = 3,
  parameter int                     DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0] INIT_SEQ = {3'd7, 3'd4, 3'd2, 3'd0},
  localparam int                    IDXW     = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic [IDXW-1:0]  cfg_last_i,
  input  logic             cfg_we_i,
  input  logic [IDXW-1:0]  cfg_idx_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  output logic [WIDTH-1:0] q_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             tc_o,
  output logic             done_o,
  output logic             par_err_o
);

  seq_state_e      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            tc_q, tc_d;
  logic [IDXW-1:0] last_w;
  logic [IDXW-1:0] start_idx_w;
  logic            oneshot_w;

  assign last_w      = ({1'b0, cfg_last_i} > (IDXW+1)'(DEPTH-1)) ? IDXW'(DEPTH-1) : cfg_last_i;
  assign start_idx_w = (dir_i == DIR_UP) ? '0 : last_w;
  assign oneshot_w   = (mode_i == MODE_ONESHOT);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tc_d    = 1'b0;
    if (stop_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else if (start_i) begin
      state_d = S_RUN;
      idx_d   = start_idx_w;
    end else if (state_q == S_RUN && en_i) begin
      if (dir_i == DIR_UP) begin
        if (idx_q >= last_w) begin
          if (oneshot_w) begin
            idx_d   = last_w;
            state_d = S_DONE;
          end else begin
            idx_d = '0;
            tc_d  = 1'b1;
          end
        end else begin
          idx_d = idx_q + IDXW'(1);
          if (oneshot_w && idx_d == last_w) state_d = S_DONE;
        end
      end else begin
        // An index left above a shrunken last entry steps onto it without a wrap.
        if (idx_q == '0) begin
          if (oneshot_w) begin
            state_d = S_DONE;
          end else begin
            idx_d = last_w;
            tc_d  = 1'b1;
          end
        end else if (idx_q > last_w) begin
          idx_d = last_w;
          if (oneshot_w && last_w == '0) state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
          if (oneshot_w && idx_d == '0) state_d = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tc_q    <= tc_d;
    end
  end

  seq_cnt_table #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .INIT_SEQ(INIT_SEQ),
    .IDXW    (IDXW)
  ) u_tbl (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (cfg_we_i),
    .wr_idx_i (cfg_idx_i),
    .wr_data_i(cfg_data_i),
    .rd_idx_i (idx_q),
    .rd_data_o(q_o),
    .par_clr_i(start_i & ~stop_i),
    .par_err_o(par_err_o)
  );

  assign idx_o  = idx_q;
  assign tc_o   = tc_q;
  assign done_o = (state_q == S_DONE);

endmodule
